icache_dm: RTL

- Direct-mapped, read-only instruction cache between the CPU fetch port and the external instruction memory bus.
- Drives the CPU's i_valid_i and i_data_in_i from its o_addr_i.
- Hits complete combinationally in the cycle the address is presented.
- Misses stall the core via o_valid low while a whole line is refilled over a word-beat bus.
- A flush input supports fence.i.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_store.sv | 36 +++
 rtl/icache_dm.sv | 120 ++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared geometry helpers and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int lines, input int line_words);
      return 30 - $clog2(line_words) - $clog2(lines);
   endfunction

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   // Control state grouped so checkers can bind to one observable struct.
   typedef struct packed {
      state_t state;
      logic   flush_pending;
   } ctl_t;

endpackage

// File: rtl/icache_store.sv
// Tag and data arrays: asynchronous read for the hit path, one synchronous write port for refill.
module icache_store
   import icache_pkg::*;
#(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic                                   i_clk,
   input  logic [idx_w(LINES)-1:0]                rd_idx,
   input  logic [off_w(LINE_WORDS)-1:0]           rd_word,
   output logic [tag_w(LINES, LINE_WORDS)-1:0]    rd_tag,
   output logic [31:0]                            rd_data,
   input  logic                                   data_we,
   input  logic                                   tag_we,
   input  logic [idx_w(LINES)-1:0]                wr_idx,
   input  logic [off_w(LINE_WORDS)-1:0]           wr_word,
   input  logic [31:0]                            wr_data,
   input  logic [tag_w(LINES, LINE_WORDS)-1:0]    wr_tag
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(LINES, LINE_WORDS);

   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES*LINE_WORDS];

   assign rd_tag  = tag_mem[rd_idx];
   assign rd_data = data_mem[{rd_idx, rd_word}];

   always_ff @(posedge i_clk) begin
      if (data_we) data_mem[{wr_idx, wr_word}] <= wr_data;
      if (tag_we)  tag_mem[wr_idx] <= wr_tag;
   end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hits, line refill over a
// word-beat bus (o_mem_req held until i_mem_ack), and a one-line-per-cycle flush sweep.
module icache_dm
   import icache_pkg::*;
#(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_addr,
   output logic [31:0] o_data,
   output logic        o_valid,
   input  logic        i_flush,
   output logic        o_flush_busy,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic [31:0] i_mem_data,
   input  logic        i_mem_ack
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(LINES, LINE_WORDS);
   localparam logic [OFF_W-1:0] LAST_BEAT  = OFF_W'(LINE_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_SWEEP = IDX_W'(LINES - 1);

   ctl_t             ctl;
   logic [LINES-1:0] valid;
   logic [OFF_W-1:0] beat;
   logic [IDX_W-1:0] sweep;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;

   logic [OFF_W-1:0] word;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] tag;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;
   logic             hit;
   logic             beat_done;
   logic             addr_unused;

   assign word        = i_addr[2 +: OFF_W];
   assign index       = i_addr[2+OFF_W +: IDX_W];
   assign tag         = i_addr[31 -: TAG_W];
   assign addr_unused = ^i_addr[1:0];

   assign hit          = (ctl.state == IDLE) && valid[index] && (rd_tag == tag);
   assign o_valid      = hit;
   assign o_data       = hit ? rd_data : 32'd0;
   assign o_flush_busy = ctl.flush_pending || (ctl.state == FLUSH);
   assign beat_done    = (ctl.state == REFILL) && o_mem_req && i_mem_ack;

   icache_store #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) u_store (
      .i_clk   (i_clk),
      .rd_idx  (index),
      .rd_word (word),
      .rd_tag  (rd_tag),
      .rd_data (rd_data),
      .data_we (beat_done),
      .tag_we  (beat_done && (beat == LAST_BEAT)),
      .wr_idx  (fill_idx),
      .wr_word (beat),
      .wr_data (i_mem_data),
      .wr_tag  (fill_tag)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctl.state         <= IDLE;
         ctl.flush_pending <= 1'b0;
         valid             <= '0;
         beat              <= '0;
         sweep             <= '0;
         fill_idx          <= '0;
         fill_tag          <= '0;
         o_mem_req         <= 1'b0;
         o_mem_addr        <= 32'd0;
      end else begin
         case (ctl.state)
            IDLE: begin
               // A flush pulse wins over a simultaneous miss; the miss retries after the sweep.
               if (i_flush) begin
                  ctl.state <= FLUSH;
                  sweep     <= '0;
               end else if (!hit) begin
                  ctl.state  <= REFILL;
                  o_mem_addr <= {i_addr[31:2+OFF_W], {(2+OFF_W){1'b0}}};
                  fill_idx   <= index;
                  fill_tag   <= tag;
                  beat       <= '0;
                  o_mem_req  <= 1'b1;
               end
            end
            REFILL: begin
               if (i_flush) ctl.flush_pending <= 1'b1;
               if (beat_done) begin
                  beat       <= beat + 1'b1;
                  o_mem_addr <= o_mem_addr + 32'd4;
                  if (beat == LAST_BEAT) begin
                     valid[fill_idx]   <= 1'b1;
                     o_mem_req         <= 1'b0;
                     ctl.flush_pending <= 1'b0;
                     sweep             <= '0;
                     ctl.state         <= (ctl.flush_pending || i_flush) ? FLUSH : IDLE;
                  end
               end
            end
            FLUSH: begin
               valid[sweep] <= 1'b0;
               sweep        <= sweep + 1'b1;
               if (sweep == LAST_SWEEP) ctl.state <= IDLE;
            end
            default: ctl.state <= IDLE;
         endcase
      end
   end

endmodule
